clock_divider: RTL and testbench

Integer clock divider. Derives a slower, registered, glitch-free clock from one input clock by a fixed divisor set at elaboration. It sits at the clock-generation front of a design, for example turning a 50 MHz board clock into a lower-rate enable or clock for downstream logic. The output is purely a function of cycle count since reset.

---
 rtl/clock_divider_pkg.sv | 17 +
 rtl/clock_divider_mod_counter.sv | 35 +++
 rtl/clock_divider.sv | 55 +++++
 tb/tb_clock_divider.sv | 116 +++++++++++
 4 files changed

// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the integer clock divider.
package clock_divider_pkg;

  localparam int unsigned MinDivisor = 2;
  localparam int unsigned MaxDivisor = 2 ** 28;

  // Input cycles spent low per output period (odd divisors favour the low phase).
  function automatic int unsigned low_cycles(input int unsigned divisor);
    return (divisor + 1) / 2;
  endfunction

  // Input cycles spent high per output period.
  function automatic int unsigned high_cycles(input int unsigned divisor);
    return divisor / 2;
  endfunction

endpackage

// File: rtl/clock_divider_mod_counter.sv
// Modulo-N up-counter: counts 0 .. Modulus-1 and wraps, exposing the next count.
module mod_counter #(
  parameter int unsigned Modulus = 2,
  parameter int unsigned CntW    = $clog2(Modulus)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic [CntW-1:0] cnt_next_o
);

  localparam logic [CntW-1:0] LastCnt = CntW'(Modulus - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Wrap to zero at the terminal count so the counter never reaches Modulus.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (cnt_q == LastCnt) begin
      cnt_d = '0;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/clock_divider.sv
// Integer clock divider: registered, glitch-free output at clock_in / DIVISOR.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int unsigned DIVISOR = 2,
  parameter int unsigned CNT_W   = $clog2(DIVISOR)
) (
  input  logic clock_in,
  input  logic reset_n,
  output logic clock_out
);

  localparam int unsigned LOW_CYCLES  = low_cycles(DIVISOR);
  localparam int unsigned HIGH_CYCLES = high_cycles(DIVISOR);
  localparam logic [CNT_W-1:0] LowCnt = CNT_W'(LOW_CYCLES);

  if ((DIVISOR < MinDivisor) || (DIVISOR > MaxDivisor)) begin : g_bad_divisor
    $error("clock_divider: DIVISOR %0d outside [%0d, %0d]", DIVISOR, MinDivisor, MaxDivisor);
  end

  if ((LOW_CYCLES + HIGH_CYCLES) != DIVISOR) begin : g_bad_split
    $error("clock_divider: phase split %0d+%0d does not equal DIVISOR %0d",
           LOW_CYCLES, HIGH_CYCLES, DIVISOR);
  end

  logic [CNT_W-1:0] cnt_next;
  logic             clock_out_q;
  logic             clock_out_d;

  mod_counter #(
    .Modulus (DIVISOR),
    .CntW    (CNT_W)
  ) u_counter (
    .clk_i      (clock_in),
    .rst_ni     (reset_n),
    .cnt_next_o (cnt_next)
  );

  // Output is low for the first LOW_CYCLES counts of each period, high for the rest.
  always_comb begin
    clock_out_d = (cnt_next >= LowCnt);
  end

  // Output flop; clock_out is never a combinational function of clock_in.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      clock_out_q <= 1'b0;
    end else begin
      clock_out_q <= clock_out_d;
    end
  end

  assign clock_out = clock_out_q;

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider at several divisors sharing one clock and reset.
module tb_clock_divider;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic out2, out3, out4, out5, out1k;

  int n_cmp  = 0;
  int n_fail = 0;

  // Hand-computed output patterns, indexed by (edge - 1) % DIVISOR.
  int exp2[2]  = '{1, 0};
  int exp3[3]  = '{0, 1, 0};
  int exp4[4]  = '{0, 1, 1, 0};
  int exp5[5]  = '{0, 0, 1, 1, 0};
  int cnt3[3]  = '{1, 2, 0};

  int rises1k;
  int first_rise1k;
  logic prev1k;

  always #10 clk = ~clk;

  clock_divider #(.DIVISOR(2))    u_dut2  (.clock_in(clk), .reset_n(rst_n), .clock_out(out2));
  clock_divider #(.DIVISOR(3))    u_dut3  (.clock_in(clk), .reset_n(rst_n), .clock_out(out3));
  clock_divider #(.DIVISOR(4))    u_dut4  (.clock_in(clk), .reset_n(rst_n), .clock_out(out4));
  clock_divider #(.DIVISOR(5))    u_dut5  (.clock_in(clk), .reset_n(rst_n), .clock_out(out5));
  clock_divider #(.DIVISOR(1024)) u_dut1k (.clock_in(clk), .reset_n(rst_n), .clock_out(out1k));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_d2"}, 32'(out2), 0);
    check({tag, "_d3"}, 32'(out3), 0);
    check({tag, "_d4"}, 32'(out4), 0);
    check({tag, "_d5"}, 32'(out5), 0);
    check({tag, "_d1024"}, 32'(out1k), 0);
  endtask

  task automatic check_small(input int k);
    check($sformatf("d2_edge%0d", k), 32'(out2), exp2[(k - 1) % 2]);
    check($sformatf("d3_edge%0d", k), 32'(out3), exp3[(k - 1) % 3]);
    check($sformatf("d3_cnt_edge%0d", k), 32'(u_dut3.u_counter.cnt_q), cnt3[(k - 1) % 3]);
    check($sformatf("d4_edge%0d", k), 32'(out4), exp4[(k - 1) % 4]);
    check($sformatf("d5_edge%0d", k), 32'(out5), exp5[(k - 1) % 5]);
  endtask

  initial begin
    // Held in reset: outputs and counter at zero.
    repeat (3) @(posedge clk);
    #1;
    check_all_low("reset");
    check("reset_d3_cnt", 32'(u_dut3.u_counter.cnt_q), 0);

    @(negedge clk);
    rst_n = 1'b1;

    // 40 edges: 10 full periods of DIVISOR=4, 8 of DIVISOR=5.
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      check_small(k);
    end

    // Edges 41, 42 put DIVISOR=4 into its high phase.
    for (int k = 41; k <= 42; k++) begin
      @(posedge clk);
      #1;
      check_small(k);
    end
    check("d4_high_before_reset", 32'(out4), 1);

    // Asynchronous reset between edges drops every output without a clock edge.
    #4;
    rst_n = 1'b0;
    #1;
    check_all_low("midreset");

    @(negedge clk);
    rst_n = 1'b1;

    // Pattern restarts from edge 1; also run DIVISOR=1024 over 3 full periods.
    rises1k      = 0;
    first_rise1k = 0;
    prev1k       = 1'b0;
    for (int k = 1; k <= 3072; k++) begin
      @(posedge clk);
      #1;
      if (k <= 8) begin
        check_small(k);
      end
      if (k == 511) check("d1024_edge511", 32'(out1k), 0);
      if (k == 512) check("d1024_edge512", 32'(out1k), 1);
      if (k == 1023) check("d1024_edge1023", 32'(out1k), 1);
      if (k == 1024) check("d1024_edge1024", 32'(out1k), 0);
      if (out1k && !prev1k) begin
        rises1k++;
        if (first_rise1k == 0) first_rise1k = k;
      end
      prev1k = out1k;
    end
    check("d1024_rise_count", 32'(rises1k), 3);
    check("d1024_first_rise", 32'(first_rise1k), 512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
